filter_load_ctrl: RTL and testbench
===================================

Name: filter_load_ctrl

Overview:
Sequencing controller for the 4x4-byte filter buffer.
- On start, fetches four 32-bit filter rows from memory through a req/valid read port.
- Writes each row into the buffer, driving its write-enable, row index and data.
- Then holds filter_ready and gates the buffer read-enable for the downstream convolution datapath.
- Sits between the memory/loader interface and the filter buffer in the CNN accelerator.

Parameters:
ADDR_W, 16, memory address width
ROWS, 4, filter rows to load; the row index is 2 bits, so ROWS must be ≤4
ROW_STRIDE, 1, address increment between consecutive rows

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin loading a filter (one-cycle pulse or level)
base_addr  input  ADDR_W  address of filter row 0, sampled when start is accepted
clear  input  1  invalidate filter and return to IDLE
mem_req  output  1  one-cycle memory read request
mem_addr  output  ADDR_W  read address, valid while mem_req=1
mem_valid  input  1  read data valid
mem_rdata  input  32  read data, row bytes MSB-first
buf_we  output  1  filter buffer write enable
buf_row  output  2  filter buffer row index
buf_data  output  32  filter buffer write data
rd_en  input  1  consumer request to read the filter
buf_re  output  1  filter buffer read enable
filter_ready  output  1  complete filter resident in buffer
busy  output  1  load in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, row_cnt=0, addr_reg=0.
  - All outputs 0: mem_req, mem_addr, buf_we, buf_row, buf_data, buf_re, filter_ready, busy.
  - On release, the first transition occurs on the next rising edge.
- States: IDLE, FETCH, WAIT, WRITE, READY. All outputs are registered except buf_re.
- IDLE:
  - start=1 → latch addr_reg=base_addr, row_cnt=0, go FETCH.
  - busy=1 from the following cycle.
- FETCH:
  - mem_req=1 for exactly one cycle.
  - mem_addr = addr_reg + row_cnt*ROW_STRIDE, truncated mod 2^ADDR_W (wrap-around permitted).
  - Go WAIT.
- WAIT:
  - Hold until mem_valid=1; no timeout.
  - On mem_valid: capture mem_rdata into buf_data, go WRITE.
- WRITE:
  - buf_we=1 for one cycle, with buf_row=row_cnt and buf_data stable.
  - If row_cnt==ROWS-1 → go READY.
  - Else row_cnt++ → go FETCH.
- READY:
  - filter_ready=1, busy=0.
  - buf_re = rd_en (combinational, only in READY); buf_re=0 in every other state.
- Latency: with mem_valid one cycle after mem_req, each row takes 3 cycles.
  - start sampled at edge 0 → first mem_req in cycle 1.
  - Last buf_we in cycle 12; filter_ready=1 from cycle 13.
- start while busy (FETCH/WAIT/WRITE): ignored.
- start in READY: reload. Latch new base_addr, filter_ready=0 next cycle, go FETCH.
  - start has priority over rd_en; buf_re is forced 0 in that cycle.
- clear in any state: go IDLE next edge; filter_ready=0, busy=0, row_cnt=0.
  - clear has priority over start and mem_valid.
  - A mem_valid arriving in the same cycle as clear is dropped and no buf_we is issued.
- mem_valid outside WAIT: ignored; no write, no state change.
- Reset or clear mid-load: buffer contents are undefined and filter_ready stays 0 until a full load completes.
- buf_we and buf_re are never high in the same cycle.

Test Plan:
- Basic load: rst_n pulse; start with base_addr=0x0100; memory returns 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, each one cycle after req → mem_addr 0x0100..0x0103; buf_we in cycles 3, 6, 9, 12 with buf_row 0..3 and matching buf_data; filter_ready=1 at cycle 13; buf_re follows rd_en.
- Variable memory latency: mem_valid delayed 5 cycles on row 2 → FSM holds in WAIT, no extra mem_req, row 2 written once with correct data, filter_ready delayed by 4 cycles.
- Address wrap: base_addr=0xFFFE, ROW_STRIDE=1 → mem_addr 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Start during load and spurious valid: start pulsed in WAIT, plus mem_valid pulsed in FETCH → both ignored; exactly 4 writes; base address unchanged.
- Reload and clear: in READY, start with base_addr=0x0200 → filter_ready=0 next cycle, new fetch from 0x0200; clear asserted together with mem_valid on row 1 → IDLE, no buf_we, busy=0.
- Async reset mid-load: rst_n=0 in WRITE → all outputs 0 immediately (before the next edge); after release, start reloads from row 0.

Source files
------------

// File: rtl/filter_load_ctrl.sv
// Filter buffer load sequencer: fetches ROWS filter rows over a req/valid
// read port, writes them into the buffer, then gates buffer reads.
module filter_load_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int ROWS       = 4,
    parameter int ROW_STRIDE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              clear,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_we,
    output logic [1:0]        buf_row,
    output logic [31:0]       buf_data,
    input  logic              rd_en,
    output logic              buf_re,
    output logic              filter_ready,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        WRITE,
        READY
    } state_t;

    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

    state_t            state_q, state_d;
    logic [1:0]        row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              buf_we_q, buf_we_d;
    logic [1:0]        buf_row_q, buf_row_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    // Row address wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] row_addr(
        input logic [ADDR_W-1:0] base,
        input logic [1:0]        row
    );
        return base + ADDR_W'(row) * ADDR_W'(ROW_STRIDE);
    endfunction

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        addr_d     = addr_q;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;
        buf_we_d   = 1'b0;
        buf_row_d  = buf_row_q;
        buf_data_d = buf_data_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;

        if (clear) begin
            state_d = IDLE;
            row_d   = 2'd0;
        end else begin
            unique case (state_q)
                IDLE, READY: begin
                    if (start) begin
                        state_d    = FETCH;
                        addr_d     = base_addr;
                        row_d      = 2'd0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = base_addr;
                        busy_d     = 1'b1;
                    end else begin
                        ready_d = (state_q == READY);
                    end
                end
                FETCH: begin
                    state_d = WAIT;
                    busy_d  = 1'b1;
                end
                WAIT: begin
                    busy_d = 1'b1;
                    if (mem_valid) begin
                        state_d    = WRITE;
                        buf_data_d = mem_rdata;
                        buf_row_d  = row_q;
                        buf_we_d   = 1'b1;
                    end
                end
                WRITE: begin
                    if (row_q == LAST_ROW) begin
                        state_d = READY;
                        ready_d = 1'b1;
                    end else begin
                        state_d    = FETCH;
                        row_d      = row_q + 2'd1;
                        mem_req_d  = 1'b1;
                        mem_addr_d = row_addr(addr_q, row_q + 2'd1);
                        busy_d     = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= 2'd0;
            addr_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            buf_we_q   <= 1'b0;
            buf_row_q  <= 2'd0;
            buf_data_q <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            buf_we_q   <= buf_we_d;
            buf_row_q  <= buf_row_d;
            buf_data_q <= buf_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    // A reload request wins over a read in the same cycle.
    assign buf_re       = (state_q == READY) && rd_en && !start;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign buf_we       = buf_we_q;
    assign buf_row      = buf_row_q;
    assign buf_data     = buf_data_q;
    assign filter_ready = ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl with a memory responder
// and a write/address scoreboard.
module tb_filter_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic        clear;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        buf_we;
    logic [1:0]  buf_row;
    logic [31:0] buf_data;
    logic        rd_en;
    logic        buf_re;
    logic        filter_ready;
    logic        busy;

    filter_load_ctrl #(.ADDR_W(16), .ROWS(4), .ROW_STRIDE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .clear(clear), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .buf_we(buf_we),
        .buf_row(buf_row), .buf_data(buf_data), .rd_en(rd_en),
        .buf_re(buf_re), .filter_ready(filter_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] aq[$];
    logic [33:0] wq[$];
    int          wcyc[$];
    logic [31:0] mdat[4];
    int          lat[4];
    int          resp_row, resp_limit, pend;
    int          cnt, t0, mon_cyc, nreq;
    logic        s_ready, s_busy, s_re, s_req;
    int          rc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: monitor at negedge, responder drives after posedge.
    task automatic cyc();
        @(negedge clk);
        mon_cyc = cnt - t0 + 1;
        s_ready = filter_ready;
        s_busy  = busy;
        s_re    = buf_re;
        s_req   = mem_req;
        chk("we_re_excl", 64'(buf_we & buf_re), 64'd0);
        if (mem_req) begin
            nreq++;
            if (aq.size() == 0) chk("spurious_req", 64'd1, 64'd0);
            else chk("mem_addr", 64'(mem_addr), 64'(aq.pop_front()));
            if (resp_row < resp_limit) pend = lat[resp_row];
        end
        if (buf_we) begin
            wcyc.push_back(mon_cyc);
            if (wq.size() == 0) chk("spurious_we", 64'd1, 64'd0);
            else chk("buf_write", 64'({buf_row, buf_data}),
                     64'(wq.pop_front()));
        end
        @(posedge clk);
        cnt++;
        #1;
        mem_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mem_valid = 1'b1;
                mem_rdata = mdat[resp_row];
                wq.push_back({2'(resp_row), mdat[resp_row]});
                resp_row++;
            end
        end
    endtask

    task automatic start_load(input logic [15:0] b, input int nrows);
        logic [15:0] a;
        for (int i = 0; i < nrows; i++) begin
            a = b + 16'(i);
            aq.push_back(a);
        end
        resp_row  = 0;
        wcyc.delete();
        base_addr = b;
        start     = 1'b1;
        cyc();
        start = 1'b0;
        t0    = cnt;
    endtask

    task automatic wait_ready(input int budget, output int r);
        r = -1;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (s_ready) begin
                r = mon_cyc;
                break;
            end
        end
    endtask

    task automatic set_mem(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        mdat[0] = d0; mdat[1] = d1; mdat[2] = d2; mdat[3] = d3;
        for (int i = 0; i < 4; i++) lat[i] = 1;
        resp_limit = 4;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; clear = 1'b0;
        mem_valid = 1'b0; mem_rdata = '0; rd_en = 1'b0;
        cnt = 0; t0 = 0; pend = 0; nreq = 0; resp_row = 0;
        set_mem(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10);
        #2;
        chk("reset_outputs", 64'({mem_req, mem_addr, buf_we, buf_row,
            buf_data, buf_re, filter_ready, busy}), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Basic load
        start_load(16'h0100, 4);
        cyc();
        chk("busy_after_start", 64'(s_busy), 64'd1);
        wait_ready(40, rc);
        chk("basic_ready_cycle", 64'(rc), 64'd13);
        chk("basic_nwrites", 64'(wcyc.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < wcyc.size())
                chk("basic_we_cycle", 64'(wcyc[i]), 64'(3 * i + 3));
        chk("busy_in_ready", 64'(busy), 64'd0);
        rd_en = 1'b1;
        cyc();
        chk("buf_re_follow", 64'(s_re), 64'd1);
        rd_en = 1'b0;
        cyc();
        chk("buf_re_low", 64'(s_re), 64'd0);

        // Variable latency on row 2 (valid 5 cycles after req)
        set_mem(32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3);
        lat[2] = 5;
        start_load(16'h0040, 4);
        wait_ready(60, rc);
        chk("slow_ready_cycle", 64'(rc), 64'd17);
        chk("slow_nwrites", 64'(wcyc.size()), 64'd4);
        chk("slow_aq_empty", 64'(aq.size()), 64'd0);

        // Address wrap
        set_mem(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        start_load(16'hFFFE, 4);
        wait_ready(40, rc);
        chk("wrap_ready_cycle", 64'(rc), 64'd13);
        chk("wrap_aq_empty", 64'(aq.size()), 64'd0);

        // Start during WAIT and spurious valid during FETCH
        set_mem(32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);
        start_load(16'h0800, 4);
        cyc();
        start = 1'b1; base_addr = 16'h5555;
        cyc();
        start = 1'b0;
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        wait_ready(40, rc);
        chk("ignore_ready_cycle", 64'(rc), 64'd13);
        chk("ignore_nwrites", 64'(wcyc.size()), 64'd4);
        chk("ignore_aq_empty", 64'(aq.size()), 64'd0);

        // Reload from READY with a concurrent read request
        set_mem(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0);
        resp_limit = 1;
        rd_en = 1'b1;
        start_load(16'h0200, 2);
        rd_en = 1'b0;
        chk("reload_re_blocked", 64'(s_re), 64'd0);
        chk("reload_ready_still", 64'(s_ready), 64'd1);
        cyc();
        chk("reload_ready_drop", 64'(s_ready), 64'd0);
        chk("reload_req", 64'(s_req), 64'd1);
        nreq = 1;
        for (int i = 0; i < 20 && nreq < 2; i++) cyc();
        chk("reload_row1_req", 64'(nreq), 64'd2);
        mem_valid = 1'b1; mem_rdata = 32'hBAD0BAD0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc(); cyc(); cyc();
        chk("clear_busy", 64'(s_busy), 64'd0);
        chk("clear_ready", 64'(s_ready), 64'd0);
        chk("clear_nwrites", 64'(wcyc.size()), 64'd1);
        chk("clear_wq_empty", 64'(wq.size()), 64'd0);
        chk("clear_aq_empty", 64'(aq.size()), 64'd0);

        // Async reset while in WRITE
        set_mem(32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D);
        start_load(16'h0300, 4);
        cyc(); cyc();
        chk("in_write_we", 64'(buf_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({mem_req, mem_addr, buf_we, buf_row,
            buf_data, buf_re, filter_ready, busy}), 64'd0);
        aq.delete(); wq.delete(); pend = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        start_load(16'h0300, 4);
        wait_ready(40, rc);
        chk("after_rst_ready_cycle", 64'(rc), 64'd13);
        chk("after_rst_nwrites", 64'(wcyc.size()), 64'd4);
        chk("after_rst_aq_empty", 64'(aq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
